// File: rtl/ca_matrix_pipeline.sv
// Streaming 3x3 signed fixed-point colour-matrix engine: multiply, round, saturate.
// Three-stage pipeline with valid/ready backpressure and frame-aligned
// double-buffered coefficient updates.
module ca_matrix_pipeline #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned COEF_W    = 32,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3*DATA_W-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sof,
  input  logic [9*COEF_W-1:0]   coef_in,
  input  logic                  coef_load,
  input  logic                  bypass,
  output logic [3*DATA_W-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sof,
  output logic                  coef_pending,
  output logic                  busy,
  output logic [15:0]           clip_count
);

  localparam int unsigned PIX_W  = 3 * DATA_W;
  localparam int unsigned MAT_W  = 9 * COEF_W;
  localparam int unsigned PROD_W = COEF_W + DATA_W + 1;
  localparam int unsigned SUM_W  = PROD_W + 2;
  localparam logic [SUM_W-1:0] ROUND_K  = SUM_W'(1) << (FRAC_BITS - 1);
  localparam logic [15:0]      CLIP_MAX = 16'hFFFF;

  // Identity matrix in the packed row-major coefficient layout.
  function automatic logic [MAT_W-1:0] identity_mat();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int r = 0; r < 3; r++) m[(4*r)*COEF_W +: COEF_W] = COEF_W'(1) << FRAC_BITS;
    return m;
  endfunction

  logic                     advance, accept, swap, pipe_busy;
  logic [MAT_W-1:0]         coef_sel;
  logic [MAT_W-1:0]         active_q, active_d, shadow_q, shadow_d;
  logic                     pending_q, pending_d;

  logic                     s1_valid_q, s1_valid_d, s1_bypass_q, s1_bypass_d, s1_sof_q, s1_sof_d;
  logic [PIX_W-1:0]         s1_raw_q, s1_raw_d;
  logic signed [PROD_W-1:0] prod_q [9];
  logic signed [PROD_W-1:0] prod_d [9];

  logic                     s2_valid_q, s2_valid_d, s2_bypass_q, s2_bypass_d, s2_sof_q, s2_sof_d;
  logic [PIX_W-1:0]         s2_raw_q, s2_raw_d;
  logic signed [SUM_W-1:0]  row_sum [3];
  logic signed [SUM_W-1:0]  row_q [3];
  logic signed [SUM_W-1:0]  row_d [3];

  logic [PIX_W-1:0]         sat_pix;
  logic [2:0]               sat_clip;
  logic                     out_valid_q, out_valid_d, out_sof_q, out_sof_d;
  logic [PIX_W-1:0]         out_data_q, out_data_d;
  logic [15:0]              clip_count_q, clip_count_d;

  // Global advance and coefficient double-buffer control.
  always_comb begin
    pipe_busy = s1_valid_q || s2_valid_q || out_valid_q;
    advance   = out_ready || !out_valid_q;
    accept    = in_valid && advance;
    swap      = pending_q && ((accept && in_sof) || (!in_valid && !pipe_busy));
    coef_sel  = swap ? shadow_q : active_q;
    active_d  = coef_sel;
    shadow_d  = coef_load ? coef_in : shadow_q;
    pending_d = coef_load || (pending_q && !swap);
  end

  // Stage 1: nine signed coefficient x channel products.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_bypass_d = s1_bypass_q;
    s1_sof_d    = s1_sof_q;
    s1_raw_d    = s1_raw_q;
    prod_d      = prod_q;
    if (advance) begin
      s1_valid_d  = in_valid;
      s1_bypass_d = bypass;
      s1_sof_d    = in_sof;
      s1_raw_d    = in_data;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          prod_d[r*3+c] = PROD_W'($signed(coef_sel[(r*3+c)*COEF_W +: COEF_W]))
                        * PROD_W'($signed({1'b0, in_data[c*DATA_W +: DATA_W]}));
        end
      end
    end
  end

  // Stage 2: per-row sum, round half up, drop fractional bits.
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_bypass_d = s2_bypass_q;
    s2_sof_d    = s2_sof_q;
    s2_raw_d    = s2_raw_q;
    row_d       = row_q;
    for (int r = 0; r < 3; r++) begin
      row_sum[r] = SUM_W'(prod_q[3*r]) + SUM_W'(prod_q[3*r+1]) + SUM_W'(prod_q[3*r+2]) + ROUND_K;
    end
    if (advance) begin
      s2_valid_d  = s1_valid_q;
      s2_bypass_d = s1_bypass_q;
      s2_sof_d    = s1_sof_q;
      s2_raw_d    = s1_raw_q;
      for (int r = 0; r < 3; r++) row_d[r] = row_sum[r] >>> FRAC_BITS;
    end
  end

  // Stage 3: saturate to the channel range, select bypass, count clipped pixels.
  always_comb begin
    sat_pix      = '0;
    sat_clip     = '0;
    out_valid_d  = out_valid_q;
    out_sof_d    = out_sof_q;
    out_data_d   = out_data_q;
    clip_count_d = clip_count_q;
    for (int r = 0; r < 3; r++) begin
      sat_clip[r] = row_q[r][SUM_W-1] || (|row_q[r][SUM_W-2:DATA_W]);
      if (row_q[r][SUM_W-1])            sat_pix[r*DATA_W +: DATA_W] = '0;
      else if (|row_q[r][SUM_W-2:DATA_W]) sat_pix[r*DATA_W +: DATA_W] = '1;
      else                              sat_pix[r*DATA_W +: DATA_W] = row_q[r][DATA_W-1:0];
    end
    if (advance) begin
      out_valid_d = s2_valid_q;
      out_sof_d   = s2_valid_q && s2_sof_q;
      if (s2_valid_q) begin
        out_data_d = s2_bypass_q ? s2_raw_q : sat_pix;
        if (!s2_bypass_q && (|sat_clip) && (clip_count_q != CLIP_MAX)) begin
          clip_count_d = clip_count_q + 16'd1;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q     <= identity_mat();
      shadow_q     <= identity_mat();
      pending_q    <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_bypass_q  <= 1'b0;
      s1_sof_q     <= 1'b0;
      s1_raw_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_bypass_q  <= 1'b0;
      s2_sof_q     <= 1'b0;
      s2_raw_q     <= '0;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_data_q   <= '0;
      clip_count_q <= '0;
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      for (int i = 0; i < 3; i++) row_q[i] <= '0;
    end else begin
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      s1_valid_q   <= s1_valid_d;
      s1_bypass_q  <= s1_bypass_d;
      s1_sof_q     <= s1_sof_d;
      s1_raw_q     <= s1_raw_d;
      s2_valid_q   <= s2_valid_d;
      s2_bypass_q  <= s2_bypass_d;
      s2_sof_q     <= s2_sof_d;
      s2_raw_q     <= s2_raw_d;
      out_valid_q  <= out_valid_d;
      out_sof_q    <= out_sof_d;
      out_data_q   <= out_data_d;
      clip_count_q <= clip_count_d;
      for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
      for (int i = 0; i < 3; i++) row_q[i] <= row_d[i];
    end
  end

  assign in_ready     = advance;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_sof      = out_sof_q;
  assign coef_pending = pending_q;
  assign busy         = pipe_busy;
  assign clip_count   = clip_count_q;

endmodule
